// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared types, limits and range helpers for the up/down event counter
package updown_counter_pkg;

  // Deepest synchroniser chain the edge_sync block will build.
  localparam int SYNC_MAX = 3;

  // Net count request seen by the datapath in one cycle.
  typedef enum logic [1:0] {
    EV_NONE,
    EV_UP,
    EV_DOWN
  } event_t;

  // Largest representable counter value for the given width and signedness.
  function automatic longint range_max(input int size, input int sgn);
    if (sgn != 0) begin
      return (longint'(1) << (size - 1)) - longint'(1);
    end
    return (longint'(1) << size) - longint'(1);
  endfunction

  // Smallest representable counter value for the given width and signedness.
  function automatic longint range_min(input int size, input int sgn);
    if (sgn != 0) begin
      return -(longint'(1) << (size - 1));
    end
    return longint'(0);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - optional input synchroniser followed by a rising-edge detector
module edge_sync
  import updown_counter_pkg::*;
#(
  parameter int Stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  // Chain depth is clamped so an out-of-range parameter still builds something sane.
  localparam int ST = (Stages > SYNC_MAX) ? SYNC_MAX : ((Stages < 0) ? 0 : Stages);

  logic s;
  logic p;

  generate
    if (ST == 0) begin : g_direct
      // Input is already synchronous to the clock; use it as-is.
      assign s = din;
    end else if (ST == 1) begin : g_one
      logic sff;
      // Single capture flop.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sff <= 1'b0;
        end else begin
          sff <= din;
        end
      end
      assign s = sff;
    end else begin : g_multi
      logic [ST-1:0] sff;
      // Shift the raw input through the chain; the oldest bit is the clean level.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sff <= '0;
        end else begin
          sff <= {sff[ST-2:0], din};
        end
      end
      assign s = sff[ST-1];
    end
  endgenerate

  // History flop holds last cycle's clean level so a held input fires only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= 1'b0;
    end else begin
      p <= s;
    end
  end

  assign rise = s & ~p;

endmodule

// File: rtl/updown_event_counter.sv
// rtl/updown_event_counter.sv - up/down event counter with step, wrap/saturate, load and bound flags
module updown_event_counter
  import updown_counter_pkg::*;
#(
  parameter int Size       = 8,
  parameter int Signed     = 1,
  parameter int Saturate   = 0,
  parameter int SyncStages = 2
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Up,
  input  logic            Down,
  input  logic            Enable,
  input  logic [Size-1:0] Step,
  input  logic            Load,
  input  logic [Size-1:0] LoadValue,
  output logic [Size-1:0] Data,
  output logic            AtMax,
  output logic            AtMin,
  output logic            Overflow
);

  // Two guard bits keep Data +/- Step exact for either signedness.
  localparam int W = Size + 2;

  localparam longint MAX_L = range_max(Size, Signed);
  localparam longint MIN_L = range_min(Size, Signed);
  localparam logic signed [W-1:0] MAXV = MAX_L[W-1:0];
  localparam logic signed [W-1:0] MINV = MIN_L[W-1:0];

  logic up_rise;
  logic dn_rise;
  event_t ev;

  logic signed [W-1:0] data_ext;
  logic signed [W-1:0] step_ext;
  logic signed [W-1:0] target;
  logic above;
  logic below;
  logic step_zero;

  edge_sync #(.Stages(SyncStages)) u_up_sync (
    .clk  (Clock),
    .rst  (Reset),
    .din  (Up),
    .rise (up_rise)
  );

  edge_sync #(.Stages(SyncStages)) u_dn_sync (
    .clk  (Clock),
    .rst  (Reset),
    .din  (Down),
    .rise (dn_rise)
  );

  // Collapse the two edge strobes into one request; simultaneous edges cancel.
  always_comb begin
    ev = EV_NONE;
    if (up_rise && !dn_rise) begin
      ev = EV_UP;
    end else if (dn_rise && !up_rise) begin
      ev = EV_DOWN;
    end
  end

  assign data_ext  = (Signed != 0) ? {{2{Data[Size-1]}}, Data} : {2'b00, Data};
  assign step_ext  = {2'b00, Step};
  assign step_zero = (Step == '0);

  // Widened target and its range check against the representable bounds.
  always_comb begin
    target = data_ext;
    if (ev == EV_UP) begin
      target = data_ext + step_ext;
    end else if (ev == EV_DOWN) begin
      target = data_ext - step_ext;
    end
    above = (target > MAXV);
    below = (target < MINV);
  end

  assign AtMax = (data_ext == MAXV);
  assign AtMin = (data_ext == MINV);

  // Counter register: load beats enable beats events; Overflow is a one-cycle pulse.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Data     <= '0;
      Overflow <= 1'b0;
    end else begin
      Overflow <= 1'b0;
      if (Load) begin
        Data <= LoadValue;
      end else if (Enable && (ev != EV_NONE) && !step_zero) begin
        if (above) begin
          Data     <= (Saturate != 0) ? MAXV[Size-1:0] : target[Size-1:0];
          Overflow <= 1'b1;
        end else if (below) begin
          Data     <= (Saturate != 0) ? MINV[Size-1:0] : target[Size-1:0];
          Overflow <= 1'b1;
        end else begin
          Data <= target[Size-1:0];
        end
      end
    end
  end

endmodule
